// File: rtl/hmc_rf_responder.sv
// hmc_rf_responder: register-file target answering single-cycle rf reads/writes
// Ports:
//   clk, res_n                 clock and asynchronous active-low reset
//   rf_address/read_en/write_en/write_data   request, sampled when a strobe is high
//   rf_read_data/access_complete/invalid_address   response, valid one cycle later
//   link_up, phy_ready, lanes_reversed, *_tokens_remaining   live status inputs
//   cnt_sent_p, cnt_sent_np, cnt_rcvd_rsp   per-cycle packet counts from TX/RX
//   ctrl_*                     control register bits 0..4
module hmc_rf_responder #(
   parameter int HMC_RF_WWIDTH      = 64,
   parameter int HMC_RF_RWIDTH      = 64,
   parameter int HMC_RF_AWIDTH      = 4,
   parameter int LOG_FPW            = 2,
   parameter int LOG_MAX_RX_TOKENS  = 10,
   parameter int LOG_MAX_HMC_TOKENS = 10
) (
   input  logic                          clk,
   input  logic                          res_n,
   input  logic [HMC_RF_AWIDTH-1:0]      rf_address,
   input  logic                          rf_read_en,
   input  logic                          rf_write_en,
   input  logic [HMC_RF_WWIDTH-1:0]      rf_write_data,
   output logic [HMC_RF_RWIDTH-1:0]      rf_read_data,
   output logic                          rf_access_complete,
   output logic                          rf_invalid_address,
   input  logic                          link_up,
   input  logic                          phy_ready,
   input  logic                          lanes_reversed,
   input  logic [LOG_MAX_HMC_TOKENS-1:0] hmc_tokens_remaining,
   input  logic [LOG_MAX_RX_TOKENS-1:0]  rx_tokens_remaining,
   input  logic [LOG_FPW:0]              cnt_sent_p,
   input  logic [LOG_FPW:0]              cnt_sent_np,
   input  logic [LOG_FPW:0]              cnt_rcvd_rsp,
   output logic                          ctrl_p_rst_n,
   output logic                          ctrl_hmc_init_cont,
   output logic                          ctrl_set_sleep,
   output logic                          ctrl_scrambler_disable,
   output logic                          ctrl_run_length_enable
);
   localparam logic [HMC_RF_AWIDTH-1:0] A_STATUS  = HMC_RF_AWIDTH'(0);
   localparam logic [HMC_RF_AWIDTH-1:0] A_CONTROL = HMC_RF_AWIDTH'(1);
   localparam logic [HMC_RF_AWIDTH-1:0] A_SENT_P  = HMC_RF_AWIDTH'(2);
   localparam logic [HMC_RF_AWIDTH-1:0] A_SENT_NP = HMC_RF_AWIDTH'(3);
   localparam logic [HMC_RF_AWIDTH-1:0] A_RCVD    = HMC_RF_AWIDTH'(4);
   localparam logic [HMC_RF_AWIDTH-1:0] A_CLEAR   = HMC_RF_AWIDTH'(5);
   logic [4:0]               ctrl;
   logic [63:0]              cnt_p, cnt_np, cnt_rsp, status;
   logic [HMC_RF_RWIDTH-1:0] rd_mux;
   logic                     rd, wr, mapped, invalid, ctrl_we, do_clear;
   // 65-bit sum so the carry-out selects saturation instead of wrapping
   function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [LOG_FPW:0] b);
      logic [64:0] s;
      s = {1'b0, a} + 65'(b);
      return s[64] ? '1 : s[63:0];
   endfunction
   // a write wins when both strobes are high
   assign wr = rf_write_en;
   assign rd = rf_read_en & ~rf_write_en;
   assign status = 64'({16'(rx_tokens_remaining), 16'(hmc_tokens_remaining), 13'b0,
                        lanes_reversed, phy_ready, link_up});
   always_comb begin
      rd_mux = '0;
      mapped = 1'b1;
      case (rf_address)
         A_STATUS:  rd_mux = HMC_RF_RWIDTH'(status);
         A_CONTROL: rd_mux = HMC_RF_RWIDTH'(ctrl);
         A_SENT_P:  rd_mux = HMC_RF_RWIDTH'(cnt_p);
         A_SENT_NP: rd_mux = HMC_RF_RWIDTH'(cnt_np);
         A_RCVD:    rd_mux = HMC_RF_RWIDTH'(cnt_rsp);
         A_CLEAR:   rd_mux = '0;
         default:   mapped = 1'b0;
      endcase
   end
   assign ctrl_we  = wr && rf_address == A_CONTROL;
   assign do_clear = wr && rf_address == A_CLEAR && rf_write_data[0];
   assign invalid  = wr ? !(rf_address == A_CONTROL || rf_address == A_CLEAR) : !mapped;
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         ctrl               <= 5'b10000;
         cnt_p              <= '0;
         cnt_np             <= '0;
         cnt_rsp            <= '0;
         rf_read_data       <= '0;
         rf_access_complete <= 1'b0;
         rf_invalid_address <= 1'b0;
      end else begin
         if (ctrl_we) ctrl <= rf_write_data[4:0];
         cnt_p   <= do_clear ? '0 : sat_add(cnt_p, cnt_sent_p);
         cnt_np  <= do_clear ? '0 : sat_add(cnt_np, cnt_sent_np);
         cnt_rsp <= do_clear ? '0 : sat_add(cnt_rsp, cnt_rcvd_rsp);
         rf_access_complete <= rd | wr;
         if (rd | wr) begin
            rf_read_data       <= wr ? '0 : rd_mux;
            rf_invalid_address <= invalid;
         end
      end
   end
   assign {ctrl_run_length_enable, ctrl_scrambler_disable, ctrl_set_sleep,
           ctrl_hmc_init_cont, ctrl_p_rst_n} = ctrl;
endmodule

// File: tb/tb_hmc_rf_responder.sv
// tb_hmc_rf_responder: scoreboard bench for the rf responder
module tb_hmc_rf_responder;
   logic        clk, res_n;
   logic [3:0]  rf_address;
   logic        rf_read_en, rf_write_en;
   logic [63:0] rf_write_data, rf_read_data;
   logic        rf_access_complete, rf_invalid_address;
   logic        link_up, phy_ready, lanes_reversed;
   logic [9:0]  hmc_tokens_remaining, rx_tokens_remaining;
   logic [2:0]  cnt_sent_p, cnt_sent_np, cnt_rcvd_rsp;
   logic        ctrl_p_rst_n, ctrl_hmc_init_cont, ctrl_set_sleep;
   logic        ctrl_scrambler_disable, ctrl_run_length_enable;
   logic [4:0]  ctrl;
   typedef struct {logic [63:0] d; logic inv;} exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;
   hmc_rf_responder dut (
      .clk(clk), .res_n(res_n), .rf_address(rf_address), .rf_read_en(rf_read_en),
      .rf_write_en(rf_write_en), .rf_write_data(rf_write_data), .rf_read_data(rf_read_data),
      .rf_access_complete(rf_access_complete), .rf_invalid_address(rf_invalid_address),
      .link_up(link_up), .phy_ready(phy_ready), .lanes_reversed(lanes_reversed),
      .hmc_tokens_remaining(hmc_tokens_remaining), .rx_tokens_remaining(rx_tokens_remaining),
      .cnt_sent_p(cnt_sent_p), .cnt_sent_np(cnt_sent_np), .cnt_rcvd_rsp(cnt_rcvd_rsp),
      .ctrl_p_rst_n(ctrl_p_rst_n), .ctrl_hmc_init_cont(ctrl_hmc_init_cont),
      .ctrl_set_sleep(ctrl_set_sleep), .ctrl_scrambler_disable(ctrl_scrambler_disable),
      .ctrl_run_length_enable(ctrl_run_length_enable)
   );
   assign ctrl = {ctrl_run_length_enable, ctrl_scrambler_disable, ctrl_set_sleep,
                  ctrl_hmc_init_cont, ctrl_p_rst_n};
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // monitor: every complete must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (res_n && rf_access_complete) begin
         if (q.size() == 0) chk("unexpected_complete", 64'd1, 64'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_data", rf_read_data, e.d);
            chk("rsp_invalid", 64'(rf_invalid_address), 64'(e.inv));
         end
      end
   end
   task automatic issue(input logic rd, input logic wr, input logic [3:0] a,
                        input logic [63:0] wd, input logic [63:0] ed, input logic ei);
      exp_t e;
      @(negedge clk);
      rf_read_en = rd; rf_write_en = wr; rf_address = a; rf_write_data = wd;
      e.d = ed; e.inv = ei;
      q.push_back(e);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rf_read_en = 1'b0; rf_write_en = 1'b0;
      end
   endtask
   initial begin
      res_n = 1'b0; rf_address = '0; rf_read_en = 1'b0; rf_write_en = 1'b0; rf_write_data = '0;
      link_up = 1'b1; phy_ready = 1'b0; lanes_reversed = 1'b1;
      hmc_tokens_remaining = 10'h3FF; rx_tokens_remaining = 10'h155;
      cnt_sent_p = '0; cnt_sent_np = '0; cnt_rcvd_rsp = '0;
      repeat (3) @(negedge clk);
      chk("reset_complete", 64'(rf_access_complete), 64'd0);
      chk("reset_data", rf_read_data, 64'd0);
      chk("reset_invalid", 64'(rf_invalid_address), 64'd0);
      chk("reset_ctrl", 64'(ctrl), 64'h10);
      res_n = 1'b1;
      issue(1, 0, 4'h1, 0, 64'h10, 0); idle(1);
      issue(0, 1, 4'h1, 64'hFFFF_FFFF_FFFF_FFEB, 0, 0); idle(1);
      chk("ctrl_after_write", 64'(ctrl), 64'h0B);
      issue(1, 0, 4'h1, 0, 64'h0B, 0); idle(1);
      // SENT_P accumulation, clear, and clear colliding with an increment
      @(negedge clk); cnt_sent_p = 3'd4;
      repeat (10) @(negedge clk);
      cnt_sent_p = 3'd0;
      issue(1, 0, 4'h2, 0, 64'd40, 0); idle(1);
      issue(0, 1, 4'h5, 64'd1, 0, 0); idle(1);
      issue(1, 0, 4'h2, 0, 64'd0, 0); idle(1);
      @(negedge clk); cnt_sent_p = 3'd5;
      repeat (2) @(negedge clk);
      issue(0, 1, 4'h5, 64'd1, 0, 0); cnt_sent_p = 3'd3;
      idle(1); cnt_sent_p = 3'd0;
      issue(1, 0, 4'h2, 0, 64'd0, 0); idle(1);
      issue(1, 0, 4'h5, 0, 64'd0, 0); idle(1);
      // write of 0 to CNT_CLEAR leaves counters alone
      @(negedge clk); cnt_rcvd_rsp = 3'd7;
      repeat (3) @(negedge clk);
      cnt_rcvd_rsp = 3'd0;
      issue(0, 1, 4'h5, 64'd0, 0, 0); idle(1);
      issue(1, 0, 4'h4, 0, 64'd21, 0); idle(1);
      issue(0, 1, 4'h4, 64'd0, 0, 1); idle(1);
      issue(1, 0, 4'h4, 0, 64'd21, 0); idle(1);
      // saturation of SENT_NP
      @(negedge clk);
      cnt_sent_np = 3'd4;
      force dut.cnt_np = 64'hFFFF_FFFF_FFFF_FFFE;
      #1 release dut.cnt_np;
      @(negedge clk);
      @(negedge clk); cnt_sent_np = 3'd0;
      issue(1, 0, 4'h3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0); idle(1);
      // invalid accesses
      issue(1, 0, 4'h9, 0, 64'd0, 1); idle(1);
      issue(1, 0, 4'hF, 0, 64'd0, 1); idle(1);
      issue(0, 1, 4'h0, 64'hFFFF, 64'd0, 1); idle(1);
      issue(1, 0, 4'h0, 0, 64'h0000_0155_03FF_0005, 0); idle(1);
      // both strobes: write wins, data 0
      issue(1, 1, 4'h1, 64'h13, 64'd0, 0); idle(1);
      chk("ctrl_rw_both", 64'(ctrl), 64'h13);
      // back-to-back reads
      issue(1, 0, 4'h0, 0, 64'h0000_0155_03FF_0005, 0);
      issue(1, 0, 4'h1, 0, 64'h13, 0);
      idle(1);
      // reset hits while a response is pending: no complete, no expectation queued
      @(negedge clk);
      rf_read_en = 1'b1; rf_address = 4'h1;
      @(posedge clk);
      #1 res_n = 1'b0;
      @(negedge clk);
      rf_read_en = 1'b0;
      chk("no_complete_after_reset", 64'(rf_access_complete), 64'd0);
      chk("ctrl_after_reset", 64'(ctrl), 64'h10);
      @(negedge clk); res_n = 1'b1;
      issue(1, 0, 4'h3, 0, 64'd0, 0); idle(1);
      issue(1, 0, 4'h1, 0, 64'h10, 0); idle(1);
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/hmc_rf_responder.md
Name: hmc_rf_responder

Overview:
- Register-file responder for the HMC controller. It is the target end of the 64-bit register-file access interface that the rf agent drives as initiator.
- Decodes single-cycle read and write requests against a 4-bit address space and answers each with a read-data / complete / invalid-address response.
- Holds the controller's control register, a live status word, and three 64-bit saturating packet counters that are fed by the TX and RX datapaths.

Parameters:
HMC_RF_WWIDTH, 64, write data width
HMC_RF_RWIDTH, 64, read data width
HMC_RF_AWIDTH, 4, address width
LOG_FPW, 2, log2 of flits per word; per-cycle packet-count inputs are LOG_FPW+1 bits wide
LOG_MAX_RX_TOKENS, 10, width of the RX token status field
LOG_MAX_HMC_TOKENS, 10, width of the HMC token status field

Ports:
clk  in  1  sole clock
res_n  in  1  asynchronous active-low reset
rf_address  in  HMC_RF_AWIDTH  request address
rf_read_en  in  1  read request strobe, one cycle
rf_write_en  in  1  write request strobe, one cycle
rf_write_data  in  HMC_RF_WWIDTH  write data
rf_read_data  out  HMC_RF_RWIDTH  read response data
rf_access_complete  out  1  one-cycle response strobe
rf_invalid_address  out  1  qualifies rf_access_complete: address unmapped or write to read-only register
link_up  in  1  status input
phy_ready  in  1  status input
lanes_reversed  in  1  status input
hmc_tokens_remaining  in  LOG_MAX_HMC_TOKENS  status input
rx_tokens_remaining  in  LOG_MAX_RX_TOKENS  status input
cnt_sent_p  in  LOG_FPW+1  posted requests sent this cycle
cnt_sent_np  in  LOG_FPW+1  non-posted requests sent this cycle
cnt_rcvd_rsp  in  LOG_FPW+1  responses received this cycle
ctrl_p_rst_n  out  1  control bit 0
ctrl_hmc_init_cont  out  1  control bit 1
ctrl_set_sleep  out  1  control bit 2
ctrl_scrambler_disable  out  1  control bit 3
ctrl_run_length_enable  out  1  control bit 4

Behaviour:
- Reset (res_n low, asynchronous):
  - All registers and counters clear to 0, except run_length_enable, which resets to 1.
  - rf_read_data=0, rf_access_complete=0, rf_invalid_address=0.
  - A request in flight when reset asserts is dropped; no complete is issued after reset.
- Address map:
  - 0x0 STATUS, RO: [0]=link_up, [1]=phy_ready, [2]=lanes_reversed, [15:8]=zero-extended low bits of {zeros, ...} (unused, reads 0), [31:16]=hmc_tokens_remaining zero-extended, [47:32]=rx_tokens_remaining zero-extended, all other bits 0.
  - 0x1 CONTROL, RW: bits[4:0] map to the ctrl_* outputs; upper bits read 0 and ignore writes.
  - 0x2 SENT_P, RO counter.
  - 0x3 SENT_NP, RO counter.
  - 0x4 RCVD_RSP, RO counter.
  - 0x5 CNT_CLEAR, WO: writing bit0=1 clears all three counters; reads return 0 with invalid_address=0.
  - 0x6-0xF are unmapped.
- Handshake:
  - A request is sampled in the cycle rf_read_en or rf_write_en is high.
  - rf_access_complete pulses exactly one cycle later, with rf_read_data and rf_invalid_address valid in that same cycle.
  - Fully pipelined: back-to-back requests on consecutive cycles each get their own complete.
- Read and write strobes together: treated as a write; the response data is 0.
- Reads of unmapped addresses: return data 0, invalid_address=1.
- Writes to unmapped addresses or to RO registers: no state change, invalid_address=1.
- rf_read_data holds its last value when no complete is pulsing.
- CONTROL:
  - A write updates the ctrl_* outputs on the cycle rf_access_complete pulses.
  - A read in the cycle after a write returns the new value.
- Counters:
  - Each counter adds its input every cycle.
  - Each is 64-bit unsigned and saturates at 2^64-1, never wraps.
  - A clear and an increment in the same cycle leave the counter at 0; the increment is lost.
- STATUS is sampled at the request cycle; no extra synchronisation.
- Counter reads return the value before that cycle's increment.

Test Plan:
- Reset, then read 0x1 -> complete 1 cycle later, data 0x10, invalid=0; ctrl_run_length_enable=1, all other ctrl_* outputs 0.
- Write 0x1 with 0xFFFF_FFFF_FFFF_FFEB, then read 0x1 -> data 0x0B; ctrl_p_rst_n=1, ctrl_hmc_init_cont=1, ctrl_set_sleep=0, ctrl_scrambler_disable=1, ctrl_run_length_enable=0.
- cnt_sent_p=4 for 10 cycles, then read 0x2 -> 40. Write 0x5 with 1, then read 0x2 -> 0. Clear issued in the same cycle as cnt_sent_p=3 -> counter reads 0.
- Force SENT_NP to 2^64-2, then cnt_sent_np=4 for one cycle -> reads 0xFFFF_FFFF_FFFF_FFFF; a further increment leaves it unchanged.
- Read 0x9 -> data 0, invalid=1. Write 0x0 -> invalid=1, status unchanged. Read and write strobes together at 0x1 -> write applied, data 0.
- Reads to 0x0 and 0x1 on consecutive cycles -> two completes on consecutive cycles with correct data. Assert res_n low in the cycle after a request -> no complete is issued.
